// File: rtl/vram_arbiter.sv
// vram_arbiter: shares single-port video RAM between display line prefetch and CPU accesses
// Ports:
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   frame_start         pulse before first visible line (restarts frame, flushes FIFO)
//   line_start          pulse in h-blank before each display line (each source line shown twice)
//   pix_req             display pops the FIFO head
//   pix_data/pix_valid  FIFO head (0 when empty or past the last line) / FIFO non-empty
//   underflow           sticky flag: pop requested while FIFO empty
//   cpu_req/we/addr/wdata  CPU request, held until cpu_ack
//   cpu_ack/cpu_rdata   one-cycle completion pulse, read data valid with it
//   ram_addr/we/wdata/rdata  single-port RAM with 1-cycle read latency
module vram_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int LINE_PIXELS = 320,
    parameter int LINES       = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic              pix_req,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              underflow,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    localparam int CW = $clog2(LINE_PIXELS + 1);
    localparam int LW = $clog2(2 * LINES + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, FETCH} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] line_base, fetch_base;
    logic [CW-1:0]     fetch_cnt;
    logic [LW-1:0]     disp_line;
    logic              parity, blank, disp_inflight, cpu_inflight, cpu_rd, underflow_r;
    logic [DATA_W-1:0] fifo [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;
    logic [PW+1:0]     level;
    logic              accept, urgent, cpu_gnt, disp_gnt, push, pop, empty, last;

    assign accept   = line_start && disp_line < LW'(2 * LINES);
    assign empty    = count == '0;
    // FIFO occupancy plus the read whose data arrives this cycle
    assign level    = {1'b0, count} + (PW+2)'(disp_inflight);
    assign urgent   = state == FETCH && level <= (PW+2)'(1);
    // grants are gated by rst_n so the RAM port is quiet during reset
    assign cpu_gnt  = rst_n && !urgent && cpu_req && !cpu_inflight;
    // no new display read while the line/frame is being restarted
    assign disp_gnt = rst_n && !frame_start && !accept && state == FETCH && !cpu_gnt
                      && level < (PW+2)'(FIFO_DEPTH);
    assign last     = fetch_cnt == CW'(LINE_PIXELS - 1);
    // data of a read in flight at frame_start is dropped
    assign push     = disp_inflight && !frame_start;
    assign pop      = pix_req && !empty && !blank;

    assign ram_addr  = cpu_gnt ? cpu_addr : disp_gnt ? fetch_base + ADDR_W'(fetch_cnt) : '0;
    assign ram_we    = cpu_gnt && cpu_we;
    assign ram_wdata = ram_we ? cpu_wdata : '0;
    assign cpu_ack   = cpu_inflight;
    assign cpu_rdata = cpu_rd ? ram_rdata : '0;
    assign pix_valid = !empty && !blank;
    assign pix_data  = pix_valid ? fifo[rd_ptr] : '0;
    assign underflow = underflow_r;

    // an accepted line_start restarts the fetch even if the previous line is unfinished
    always_comb begin
        state_nxt = frame_start ? IDLE : accept ? FETCH : (disp_gnt && last) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= ram_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            line_base     <= '0;
            fetch_base    <= '0;
            fetch_cnt     <= '0;
            disp_line     <= '0;
            parity        <= 1'b0;
            blank         <= 1'b0;
            disp_inflight <= 1'b0;
            cpu_inflight  <= 1'b0;
            cpu_rd        <= 1'b0;
            underflow_r   <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
        end else begin
            state         <= state_nxt;
            cpu_inflight  <= cpu_gnt;
            cpu_rd        <= cpu_gnt && !cpu_we;
            disp_inflight <= disp_gnt;
            if (pix_req && empty && !blank) underflow_r <= 1'b1;
            if (disp_gnt) fetch_cnt <= fetch_cnt + CW'(1);
            if (line_start) begin
                if (disp_line != LW'(2 * LINES)) disp_line <= disp_line + LW'(1);
                parity <= !parity;
                // second display of a source line done: advance to the next source line
                if (parity) line_base <= line_base + ADDR_W'(LINE_PIXELS);
                blank <= !accept;
            end
            // the line being fetched uses the base before this line_start's update
            if (accept) begin
                fetch_cnt  <= '0;
                fetch_base <= line_base;
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
            if (frame_start) begin
                line_base     <= '0;
                parity        <= 1'b0;
                disp_line     <= '0;
                blank         <= 1'b0;
                disp_inflight <= 1'b0;
                wr_ptr        <= '0;
                rd_ptr        <= '0;
                count         <= '0;
            end
        end
    end
endmodule
